// File: rtl/rep3_serial_tx.sv
// Repetition-coded serial transmitter: frames a parallel word as start/data/stop bits,
// each bit repeated REP times with each repetition held for DIV clocks, LSB first.
module rep3_serial_tx #(
  parameter int WIDTH = 8,
  parameter int REP   = 3,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             tx,
  output logic             tx_en
);
  localparam int CCW = (DIV   > 1) ? $clog2(DIV)   : 1;
  localparam int RCW = (REP   > 1) ? $clog2(REP)   : 1;
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CCW-1:0] CC_LAST = CCW'(DIV - 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(REP - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nx;
  logic [CCW-1:0]   cc, cc_nx;
  logic [RCW-1:0]   rc, rc_nx;
  logic [BCW-1:0]   bc, bc_nx;
  logic [WIDTH-1:0] sh, sh_nx, shifted;
  logic             tx_nx, tx_en_nx, ready_nx;
  logic             chip_end, bit_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cc        <= '0;
      rc        <= '0;
      bc        <= '0;
      sh        <= '0;
      tx        <= 1'b1;
      tx_en     <= 1'b0;
      din_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      cc        <= cc_nx;
      rc        <= rc_nx;
      bc        <= bc_nx;
      sh        <= sh_nx;
      tx        <= tx_nx;
      tx_en     <= tx_en_nx;
      din_ready <= ready_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cc_nx    = cc;
    rc_nx    = rc;
    bc_nx    = bc;
    sh_nx    = sh;
    tx_nx    = tx;
    tx_en_nx = tx_en;
    ready_nx = din_ready;
    chip_end = (cc == CC_LAST);
    bit_end  = chip_end && (rc == RC_LAST);
    shifted  = sh >> 1;

    if (state == IDLE) begin
      ready_nx = 1'b1;
      tx_nx    = 1'b1;
      tx_en_nx = 1'b0;
      // Ready is the registered copy, so the release edge itself can never accept.
      if (din_valid && din_ready) begin
        state_nx = START;
        sh_nx    = din;
        cc_nx    = '0;
        rc_nx    = '0;
        bc_nx    = '0;
        tx_nx    = 1'b0;
        tx_en_nx = 1'b1;
        ready_nx = 1'b0;
      end
    end else begin
      cc_nx = chip_end ? '0 : cc + 1'b1;
      if (chip_end)
        rc_nx = (rc == RC_LAST) ? '0 : rc + 1'b1;
      if (bit_end) begin
        unique case (state)
          START: begin
            state_nx = DATA;
            tx_nx    = sh[0];
          end
          DATA: begin
            sh_nx = shifted;
            if (bc == BC_LAST) begin
              bc_nx    = '0;
              state_nx = STOP;
              tx_nx    = 1'b1;
            end else begin
              bc_nx = bc + 1'b1;
              tx_nx = shifted[0];
            end
          end
          STOP: begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
            tx_en_nx = 1'b0;
            ready_nx = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rep3_serial_tx.sv
// Scoreboarded bench: two transmitters (DIV=1 and DIV=4) share stimulus; a frame-level
// model pushes expected line values on each modelled accept, monitors pop and compare.
module tb_rep3_serial_tx;
  localparam int W = 8, R = 3, D1 = 1, D4 = 4;
  localparam int N1 = (W + 2) * R * D1;
  localparam int N4 = (W + 2) * R * D4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready1, tx1, tx_en1;
  logic         din_ready4, tx4, tx_en4;

  int checks = 0, errors = 0;

  rep3_serial_tx #(.WIDTH(W), .REP(R), .DIV(D1)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready1), .tx(tx1), .tx_en(tx_en1));

  rep3_serial_tx #(.WIDTH(W), .REP(R), .DIV(D4)) u4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready4), .tx(tx4), .tx_en(tx_en4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ready/busy bookkeeping plus the whole expected frame per accept.
  bit q1[$], q4[$];
  bit m_rdy1 = 0, m_rdy4 = 0, acc1 = 0, acc4 = 0;
  int m_rem1 = 0, m_rem4 = 0;

  always @(posedge clk) begin
    acc1 = 0;
    if (!rst_n) begin
      m_rdy1 = 0; m_rem1 = 0; q1.delete();
    end else if (m_rdy1 && din_valid) begin
      acc1 = 1; m_rdy1 = 0; m_rem1 = N1;
      for (int b = 0; b < W + 2; b++)
        repeat (R * D1) q1.push_back((b == 0) ? 1'b0 : (b == W + 1) ? 1'b1 : din[b-1]);
    end else begin
      if (m_rem1 > 0) m_rem1--;
      if (m_rem1 == 0) m_rdy1 = 1;
    end
  end

  always @(posedge clk) begin
    acc4 = 0;
    if (!rst_n) begin
      m_rdy4 = 0; m_rem4 = 0; q4.delete();
    end else if (m_rdy4 && din_valid) begin
      acc4 = 1; m_rdy4 = 0; m_rem4 = N4;
      for (int b = 0; b < W + 2; b++)
        repeat (R * D4) q4.push_back((b == 0) ? 1'b0 : (b == W + 1) ? 1'b1 : din[b-1]);
    end else begin
      if (m_rem4 > 0) m_rem4--;
      if (m_rem4 == 0) m_rdy4 = 1;
    end
  end

  // Monitors sample mid-cycle.
  always @(negedge clk) begin
    chk("ready1", int'(din_ready1), int'(m_rdy1));
    chk("tx_en1", int'(tx_en1), int'(m_rem1 > 0));
    if (tx_en1) begin
      if (q1.size() == 0) chk("tx1_unexpected_frame", 1, 0);
      else chk("tx1", int'(tx1), int'(q1.pop_front()));
    end else chk("idle_tx1", int'(tx1), 1);
  end

  always @(negedge clk) begin
    chk("ready4", int'(din_ready4), int'(m_rdy4));
    chk("tx_en4", int'(tx_en4), int'(m_rem4 > 0));
    if (tx_en4) begin
      if (q4.size() == 0) chk("tx4_unexpected_frame", 1, 0);
      else chk("tx4", int'(tx4), int'(q4.pop_front()));
    end else chk("idle_tx4", int'(tx4), 1);
  end

  // Hold a word until the chosen model accepts it (bounded).
  task automatic send(input int which, input logic [W-1:0] w);
    int n = 0;
    din = w;
    din_valid = 1'b1;
    forever begin
      @(posedge clk); #1;
      if ((which == 1 && acc1) || (which == 4 && acc4)) break;
      if (++n > 500) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((m_rem1 > 0 || m_rem4 > 0) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) chk(name, 1, 0);
  endtask

  logic [N1-1:0] cap;
  int bad;

  initial begin
    // Reset held with valid high; no frame may start until the second edge after release.
    din = 8'hA5;
    din_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    send(1, 8'hA5);
    din_valid = 1'b0;
    for (int i = 0; i < N1; i++) begin
      @(negedge clk); cap[i] = tx1;
    end
    chk("a5_waveform", int'(cap), int'(30'b111_111_000_111_000_000_111_000_111_000));
    @(negedge clk);
    chk("a5_gap_ready", int'(din_ready1), 1);

    // Back-to-back with valid held high.
    send(1, 8'h00);
    send(1, 8'hFF);
    din_valid = 1'b0;
    wait_idle("b2b_timeout");

    // Chip stretching on the DIV=4 instance.
    send(4, 8'h01);
    din_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < N4; i++) begin
      @(negedge clk);
      if (tx4 != ((i >= 12 && i < 24) || i >= 108)) bad++;
    end
    chk("div4_waveform_errors", bad, 0);
    wait_idle("div4_timeout");

    // Mid-frame reset, then a clean frame.
    send(1, 8'hC3);
    din_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_tx", int'(tx1), 1);
    chk("midreset_tx_en", int'(tx_en1), 0);
    send(1, 8'h3C);
    din_valid = 1'b0;
    wait_idle("midreset_timeout");

    // Valid pulse during a frame must be ignored.
    send(1, 8'h5A);
    din_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 din_valid = 1'b1; din = 8'hFF;
    @(posedge clk); #1 din_valid = 1'b0;
    wait_idle("holdoff_timeout");

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      din_valid = ($urandom_range(0, 2) == 0);
      din = W'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    din_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wait_idle("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
    chk("q1_drained", q1.size(), 0);
    chk("q4_drained", q4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rep3_serial_tx.md
# rep3_serial_tx

Serial repetition-code transmitter: accepts a parallel word over a valid/ready handshake and sends it LSB-first as a framed serial stream. The start bit, each data bit and the stop bit are each repeated REP times, with each repetition ("chip") lasting DIV clocks. This is the transmit end of our triple-redundant serial link; the far end recovers each bit by majority vote over its REP chips.

## Interface
- WIDTH, 8: data word width in bits, at least 1.
- REP, 3: chips per bit; odd, at least 1.
- DIV, 1: clocks per chip, at least 1.

- CLK  input  1  single clock; all state changes on the rising edge.
- RST_N  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- DIN  input  WIDTH  word to send; sampled only on the accepting edge.
- DIN_VALID  input  1  DIN holds a word to send.
- DIN_READY  output  1  block can accept a word; registered.
- TX  output  1  serial line; idles high; registered.
- TX_EN  output  1  high for every clock of a frame; registered.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- Reset (RST_N low at an edge): state IDLE, TX=1, TX_EN=0, DIN_READY=0. All counters and the shift register are cleared. Reset overrides everything, including mid-frame. A partial frame is abandoned and the line returns high on that same edge.
- DIN_READY becomes 1 on the first edge with RST_N high. It is 1 only in IDLE.
- Accept: DIN_VALID=1 and DIN_READY=1 at an edge. On that edge:
  - load DIN into the shift register;
  - state becomes START, TX=0, TX_EN=1, DIN_READY=0.
- DIN_VALID while DIN_READY=0 is ignored. The word is not queued; the source must hold it.
- START: TX=0 for REP×DIV clocks, then DATA.
- DATA: for each bit, LSB first, TX equals that bit for REP×DIV clocks; the register shifts right after each bit. After WIDTH bits, go to STOP.
- STOP: TX=1 for REP×DIV clocks. On the edge ending the last stop clock:
  - state becomes IDLE, TX_EN=0, TX stays 1, DIN_READY=1.
- Counters:
  - chip-clock counter, 0..DIV-1;
  - chip counter, 0..REP-1;
  - bit counter, 0..WIDTH-1.
  - Each counter wraps to 0 when the one below it wraps. Each is sized to clog2 of its range, minimum 1 bit.
- DIN changes after the accept edge have no effect on the frame in flight.

## Timing
- Frame length N = (WIDTH+2)×REP×DIV clocks. TX_EN is high for exactly N consecutive clocks, starting on the accept edge.
- Latency: TX first shows the start chip in the cycle immediately after the accepting edge (no extra pipeline stage).
- Minimum inter-frame gap: one IDLE clock with TX=1, TX_EN=0, DIN_READY=1. Accepts can therefore occur at most every N+1 clocks.
- If DIN_VALID stays high continuously, frames are sent back to back with exactly a 1-clock gap.
- If DIN_VALID is high while RST_N is low: no accept on that edge or on the edge that releases reset. The first accept is possible on the second edge with RST_N high.
- TX and TX_EN are glitch-free register outputs. DIN_READY is a register output.

## Test plan
- Reset: hold RST_N=0 for 3 clocks with DIN_VALID=1 -> TX=1, TX_EN=0, DIN_READY=0 throughout. DIN_READY=1 one clock after release. No frame starts before that.
- Basic frame, WIDTH=8, REP=3, DIV=1, DIN=0xA5 -> TX over 30 clocks equals 000 111 000 111 000 000 111 000 111 111. TX_EN high for exactly those 30 clocks. DIN_READY=0 for those 30 clocks, then 1.
- Back-to-back: DIN_VALID held high with DIN=0x00 then 0xFF (swap on accept) -> two 30-clock frames separated by exactly 1 clock of TX=1, TX_EN=0. The second frame is 000 followed by 27 ones.
- Chip stretching, DIV=4, REP=3, WIDTH=8, DIN=0x01 -> start low 12 clocks, bit0 high 12, bits1-7 low 84, stop high 12. Total 120 clocks.
- Mid-frame reset: assert RST_N=0 at clock 10 of a frame -> TX=1, TX_EN=0 on that edge. After release, the next accepted word (0x3C) is sent complete and correct with no residue from the old frame.
- Hold-off: pulse DIN_VALID for 1 clock while TX_EN=1 -> ignored. No extra frame, and the current frame's waveform is unchanged.
